noc_rr_interconnect: RTL and testbench

Parametrised successor to the two-master NoC→NSU merge block. Accepts packetised flits from the NoC and steers each packet by the SourceID in its header into one of SRC_NUM per-source FIFOs. It then forwards whole packets to the NSU under packet-level round-robin arbitration. The NSU→NoC return path is a pure wire pass-through, with no state.

---
 rtl/noc_ic_pkg.sv | 46 ++++
 rtl/noc_sync_fifo.sv | 48 ++++
 rtl/noc_rr_interconnect.sv | 214 +++++++++++++++++++++
 tb/tb_noc_rr_interconnect.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_ic_pkg.sv
// Shared types, constants and the round-robin pick
// for the NoC to NSU round-robin interconnect.
package noc_ic_pkg;

  typedef enum logic [1:0] {
    IN_IDLE = 2'd0,
    IN_PKT  = 2'd1,
    IN_DROP = 2'd2
  } in_state_e;

  typedef enum logic {
    EG_IDLE = 1'b0,
    EG_SEND = 1'b1
  } eg_state_e;

  // Each FIFO entry is {flit, is_header, is_tail}.
  localparam int ENTRY_FLAGS     = 2;
  localparam int DATA_WIDTH_D    = 128;
  localparam int ENTRY_W_D       = DATA_WIDTH_D + ENTRY_FLAGS;

  localparam int         HEAD_CODE_BIT_D   = 4;
  localparam logic [3:0] HEAD_CODE_H_D     = 4'hA;
  localparam logic [3:0] HEAD_CODE_E_D     = 4'hB;
  localparam int         HEAD_CODE_E_LSB_D = 53;

  // First set bit of req[0..n-1] after ptr, wrapping.
  // Returns {found, index}.
  function automatic logic [4:0] rr_pick(
    input logic [15:0] req,
    input logic [3:0]  ptr,
    input int          n
  );
    logic [4:0] r;
    int idx;
    r = '0;
    for (int k = 16; k >= 1; k--) begin
      if (k <= n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[3:0]]) r = {1'b1, idx[3:0]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// First-word-fall-through synchronous FIFO
// with full/empty/count status.
module noc_sync_fifo
  import noc_ic_pkg::*;
#(
  parameter int WIDTH = ENTRY_W_D,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign count   = wptr - rptr;
  assign full    = (count == DEPTH_C);
  assign empty   = (wptr == rptr);
  assign rd_data = mem[rptr[AW-1:0]];

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wr_data;
  end

  // Read and write pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/noc_rr_interconnect.sv
// Steers NoC packets into per-source FIFOs by SourceID
// and forwards whole packets to the NSU round-robin.
module noc_rr_interconnect
  import noc_ic_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_D,
  parameter int ID_WIDTH        = 4,
  parameter int SRC_NUM         = 4,
  parameter int FIFO_DEPTH      = 16,
  parameter int HEAD_CODE_BIT   = HEAD_CODE_BIT_D,
  parameter logic [HEAD_CODE_BIT-1:0] HEAD_CODE_H = HEAD_CODE_H_D,
  parameter logic [HEAD_CODE_BIT-1:0] HEAD_CODE_E = HEAD_CODE_E_D,
  parameter int HEAD_CODE_E_LSB = HEAD_CODE_E_LSB_D,
  parameter int DROP_CNT_W      = 16
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  input  logic [DATA_WIDTH-1:0] noc_receive_flit,
  input  logic                  noc_receive_valid,
  input  logic                  noc_receive_is_header,
  input  logic                  noc_receive_is_tail,
  output logic                  noc_receive_ready,
  output logic [DATA_WIDTH-1:0] nsu_sender_flit,
  output logic                  nsu_sender_valid,
  output logic                  nsu_sender_is_header,
  output logic                  nsu_sender_is_tail,
  input  logic                  nsu_sender_ready,
  input  logic [DATA_WIDTH-1:0] nsu_receive_flit,
  input  logic                  nsu_receive_valid,
  input  logic                  nsu_receive_is_header,
  input  logic                  nsu_receive_is_tail,
  output logic                  nsu_receive_ready,
  output logic [DATA_WIDTH-1:0] noc_sender_flit,
  output logic                  noc_sender_valid,
  output logic                  noc_sender_is_header,
  output logic                  noc_sender_is_tail,
  input  logic                  noc_sender_ready,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic [SRC_NUM-1:0]    src_pkt_pending
);

  localparam int EW  = DATA_WIDTH + ENTRY_FLAGS;
  localparam int IW  = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int SID = DATA_WIDTH - HEAD_CODE_BIT - 1;

  assign noc_sender_flit      = nsu_receive_flit;
  assign noc_sender_valid     = nsu_receive_valid;
  assign noc_sender_is_header = nsu_receive_is_header;
  assign noc_sender_is_tail   = nsu_receive_is_tail;
  assign nsu_receive_ready    = noc_sender_ready;

  // SourceID sits just below the leading check code.
  logic [ID_WIDTH-1:0] sid;
  logic                code_ok;
  logic                hdr_ok;
  logic [IW-1:0]       sid_idx;

  assign sid     = noc_receive_flit[SID -: ID_WIDTH];
  assign sid_idx = sid[IW-1:0];
  assign code_ok =
    (noc_receive_flit[DATA_WIDTH-1 -: HEAD_CODE_BIT] == HEAD_CODE_H) &&
    (noc_receive_flit[HEAD_CODE_E_LSB +: HEAD_CODE_BIT] == HEAD_CODE_E);
  assign hdr_ok  = noc_receive_valid && noc_receive_is_header &&
                   code_ok && (32'(sid) < SRC_NUM);

  in_state_e          in_q, in_d;
  logic [IW-1:0]      tgt_q, tgt_d;
  logic               in_ready;
  logic               wr_any;
  logic               drop;
  logic [SRC_NUM-1:0] full, empty, wr_en, rd_en;
  logic [EW-1:0]      rd_data [SRC_NUM];
  logic [CW-1:0]      pkt_cnt [SRC_NUM];

  // Ingress next-state, ready and write/drop decisions.
  always_comb begin
    in_d     = in_q;
    tgt_d    = tgt_q;
    in_ready = 1'b1;
    wr_any   = 1'b0;
    drop     = 1'b0;
    unique case (in_q)
      IN_IDLE: begin
        if (hdr_ok) begin
          tgt_d    = sid_idx;
          in_ready = ~full[sid_idx];
          wr_any   = in_ready;
          if (in_ready && !noc_receive_is_tail) in_d = IN_PKT;
        end else if (noc_receive_valid) begin
          drop = 1'b1;
          if (noc_receive_is_header && !noc_receive_is_tail)
            in_d = IN_DROP;
        end
      end
      IN_PKT: begin
        in_ready = ~full[tgt_q];
        wr_any   = noc_receive_valid && in_ready;
        if (wr_any && noc_receive_is_tail) in_d = IN_IDLE;
      end
      IN_DROP: begin
        if (noc_receive_valid && noc_receive_is_tail) in_d = IN_IDLE;
      end
      default: in_d = IN_IDLE;
    endcase
  end

  assign noc_receive_ready = in_ready && !noc_rst;

  // Ingress state and captured target.
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      in_q  <= IN_IDLE;
      tgt_q <= '0;
    end else begin
      in_q  <= in_d;
      tgt_q <= tgt_d;
    end
  end

  // Saturating count of discarded packets.
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) drop_cnt <= '0;
    else if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
  end

  eg_state_e     eg_q, eg_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [4:0]    pick;
  logic          pop;
  logic [EW-1:0] head;

  for (genvar i = 0; i < SRC_NUM; i++) begin : g_src
    logic inc;
    logic dec;

    assign wr_en[i] = wr_any && (tgt_d == IW'(i));
    assign rd_en[i] = pop && (gnt_q == IW'(i));
    assign inc      = wr_en[i] && noc_receive_is_tail;
    assign dec      = rd_en[i] && rd_data[i][0];
    assign src_pkt_pending[i] = (pkt_cnt[i] != '0);

    noc_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (noc_clk),
      .rst     (noc_rst),
      .wr_en   (wr_en[i]),
      .wr_data ({noc_receive_flit, noc_receive_is_header,
                 noc_receive_is_tail}),
      .rd_en   (rd_en[i]),
      .rd_data (rd_data[i]),
      .full    (full[i]),
      .empty   (empty[i]),
      .count   ()
    );

    // Complete packets held in this FIFO.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) pkt_cnt[i] <= '0;
      else if (inc && !dec) pkt_cnt[i] <= pkt_cnt[i] + 1'b1;
      else if (dec && !inc) pkt_cnt[i] <= pkt_cnt[i] - 1'b1;
    end
  end

  assign pick = rr_pick(16'(src_pkt_pending), 4'(rr_q), SRC_NUM);
  assign head = rd_data[gnt_q];

  // Egress grant, pop and round-robin pointer update.
  always_comb begin
    eg_d  = eg_q;
    gnt_d = gnt_q;
    rr_d  = rr_q;
    pop   = 1'b0;
    unique case (eg_q)
      EG_IDLE: begin
        if (pick[4]) begin
          gnt_d = pick[IW-1:0];
          eg_d  = EG_SEND;
        end
      end
      EG_SEND: begin
        pop = nsu_sender_ready && !empty[gnt_q];
        if (pop && head[0]) begin
          rr_d = gnt_q;
          eg_d = EG_IDLE;
        end
      end
      default: eg_d = EG_IDLE;
    endcase
  end

  // Egress state, grant and last-served pointer.
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      eg_q  <= EG_IDLE;
      gnt_q <= '0;
      rr_q  <= IW'(SRC_NUM - 1);
    end else begin
      eg_q  <= eg_d;
      gnt_q <= gnt_d;
      rr_q  <= rr_d;
    end
  end

  assign nsu_sender_valid     = (eg_q == EG_SEND) && !empty[gnt_q] &&
                                !noc_rst;
  assign nsu_sender_flit      = head[EW-1:ENTRY_FLAGS];
  assign nsu_sender_is_header = head[1];
  assign nsu_sender_is_tail   = head[0];

endmodule

// File: tb/tb_noc_rr_interconnect.sv
// Directed self-checking bench for the
// round-robin NoC to NSU interconnect.
module tb_noc_rr_interconnect;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          noc_rst;
  logic [DW-1:0] rx_flit;
  logic          rx_valid, rx_hdr, rx_tail, rx_ready;
  logic [DW-1:0] tx_flit;
  logic          tx_valid, tx_hdr, tx_tail, tx_ready;
  logic [DW-1:0] nr_flit;
  logic          nr_valid, nr_hdr, nr_tail, nr_ready;
  logic [DW-1:0] ns_flit;
  logic          ns_valid, ns_hdr, ns_tail, ns_ready;
  logic [3:0]    drop_cnt;
  logic [3:0]    pend;

  always #5 clk = ~clk;

  noc_rr_interconnect #(.DROP_CNT_W(4)) dut (
    .noc_clk               (clk),
    .noc_rst               (noc_rst),
    .noc_receive_flit      (rx_flit),
    .noc_receive_valid     (rx_valid),
    .noc_receive_is_header (rx_hdr),
    .noc_receive_is_tail   (rx_tail),
    .noc_receive_ready     (rx_ready),
    .nsu_sender_flit       (tx_flit),
    .nsu_sender_valid      (tx_valid),
    .nsu_sender_is_header  (tx_hdr),
    .nsu_sender_is_tail    (tx_tail),
    .nsu_sender_ready      (tx_ready),
    .nsu_receive_flit      (nr_flit),
    .nsu_receive_valid     (nr_valid),
    .nsu_receive_is_header (nr_hdr),
    .nsu_receive_is_tail   (nr_tail),
    .nsu_receive_ready     (nr_ready),
    .noc_sender_flit       (ns_flit),
    .noc_sender_valid      (ns_valid),
    .noc_sender_is_header  (ns_hdr),
    .noc_sender_is_tail    (ns_tail),
    .noc_sender_ready      (ns_ready),
    .drop_cnt              (drop_cnt),
    .src_pkt_pending       (pend)
  );

  typedef struct {
    logic [DW-1:0] f;
    logic          h;
    logic          t;
    int            c;
  } out_t;

  out_t out_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   acc_c = 0;

  task automatic check(input string tag,
                       input logic [135:0] got,
                       input logic [135:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [3:0] ch,
                                        input logic [3:0] sid,
                                        input logic [3:0] ce,
                                        input logic [15:0] tag);
    logic [DW-1:0] f;
    f = '0;
    f[127:124] = ch;
    f[123:120] = sid;
    f[56:53]   = ce;
    f[15:0]    = tag;
    return f;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!noc_rst && tx_valid && tx_ready)
      out_q.push_back('{tx_flit, tx_hdr, tx_tail, cyc});
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      nr_flit  = {$urandom, $urandom, $urandom, $urandom};
      nr_valid = 1'($urandom);
      nr_hdr   = 1'($urandom);
      nr_tail  = 1'($urandom);
      ns_ready = 1'($urandom);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("passthru",
            136'({ns_flit, ns_valid, ns_hdr, ns_tail, nr_ready}),
            136'({nr_flit, nr_valid, nr_hdr, nr_tail, ns_ready}));
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] f,
                      input logic h, input logic t);
    int n;
    rx_flit  = f;
    rx_valid = 1'b1;
    rx_hdr   = h;
    rx_tail  = t;
    n = 0;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 136'(rx_ready), 136'(1));
    acc_c = cyc;
    sync();
    rx_valid = 1'b0;
    rx_hdr   = 1'b0;
    rx_tail  = 1'b0;
  endtask

  function automatic logic [DW-1:0] pf(input int src,
                                        input int k,
                                        input int base);
    if (k == 0) return mk(4'hA, 4'(src), 4'hB, 16'(base));
    return mk(4'h0, 4'h0, 4'h0, 16'(base + k));
  endfunction

  task automatic send_pkt(input int src, input int len,
                          input int base);
    for (int k = 0; k < len; k++)
      send(pf(src, k, base), k == 0, k == len - 1);
  endtask

  task automatic expect_flit(input logic [DW-1:0] f,
                             input logic h, input logic t,
                             output int c);
    int n;
    out_t e;
    n = 0;
    c = 0;
    while (out_q.size() == 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (out_q.size() == 0) begin
      check("out_timeout", 136'(out_q.size()), 136'(1));
    end else begin
      e = out_q.pop_front();
      c = e.c;
      check("out_flit", 136'(e.f), 136'(f));
      check("out_flags", 136'({e.h, e.t}), 136'({h, t}));
    end
  endtask

  task automatic expect_pkt(input int src, input int len,
                            input int base,
                            output int c0, output int cl);
    int c;
    c0 = 0;
    cl = 0;
    for (int k = 0; k < len; k++) begin
      expect_flit(pf(src, k, base), k == 0, k == len - 1, c);
      if (k == 0) c0 = c;
      cl = c;
    end
  endtask

  task automatic do_reset;
    noc_rst  = 1'b1;
    rx_valid = 1'b0;
    rx_hdr   = 1'b0;
    rx_tail  = 1'b0;
    sync();
    noc_rst = 1'b0;
    out_q.delete();
    sync();
  endtask

  int c0, cl, t_tail;

  initial begin
    noc_rst  = 1'b1;
    rx_flit  = '0;
    rx_valid = 1'b0;
    rx_hdr   = 1'b0;
    rx_tail  = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_ready", 136'(rx_ready), 136'(0));
    check("rst_tx_valid", 136'(tx_valid), 136'(0));
    check("rst_drop_cnt", 136'(drop_cnt), 136'(0));
    check("rst_pending", 136'(pend), 136'(0));
    noc_rst = 1'b0;
    sync();

    // single 3-flit packet from source 2
    send_pkt(2, 3, 16'h0020);
    t_tail = acc_c;
    check("single_pend", 136'(pend), 136'(4'b0100));
    expect_pkt(2, 3, 16'h0020, c0, cl);
    check("single_lat", 136'(c0 - t_tail), 136'(2));
    sync();
    check("single_pend0", 136'(pend), 136'(0));
    check("single_drop", 136'(drop_cnt), 136'(0));

    // round-robin: loaded 0,3,1 -> served 0,1,3
    do_reset();
    tx_ready = 1'b0;
    send_pkt(0, 2, 16'h0100);
    send_pkt(3, 2, 16'h0130);
    send_pkt(1, 2, 16'h0110);
    tx_ready = 1'b1;
    expect_pkt(0, 2, 16'h0100, c0, cl);
    expect_pkt(1, 2, 16'h0110, c0, cl);
    expect_pkt(3, 2, 16'h0130, c0, cl);
    sync();
    // rr_ptr=3 with 0 and 3 pending -> 0 before 3
    tx_ready = 1'b0;
    send_pkt(3, 2, 16'h0140);
    send_pkt(0, 2, 16'h0150);
    send_pkt(3, 2, 16'h0160);
    tx_ready = 1'b1;
    expect_pkt(3, 2, 16'h0140, c0, cl);
    expect_pkt(0, 2, 16'h0150, c0, cl);
    expect_pkt(3, 2, 16'h0160, c0, cl);
    sync();

    // drops: bad code_h, bad SourceID, stray, bad code_e
    send(mk(4'h5, 4'h0, 4'hB, 16'h0300), 1'b1, 1'b0);
    send(mk(4'h0, 4'h0, 4'h0, 16'h0301), 1'b0, 1'b1);
    send(mk(4'hA, 4'h7, 4'hB, 16'h0310), 1'b1, 1'b0);
    send(mk(4'h0, 4'h0, 4'h0, 16'h0311), 1'b0, 1'b1);
    check("drop_two", 136'(drop_cnt), 136'(2));
    send(mk(4'h0, 4'h0, 4'h0, 16'h0320), 1'b0, 1'b0);
    send(mk(4'hA, 4'h0, 4'h3, 16'h0330), 1'b1, 1'b1);
    check("drop_four", 136'(drop_cnt), 136'(4));
    for (int i = 0; i < 11; i++)
      send(mk(4'h5, 4'h1, 4'hB, 16'(16'h0340 + i)), 1'b1, 1'b1);
    check("drop_max", 136'(drop_cnt), 136'(15));
    for (int i = 0; i < 2; i++)
      send(mk(4'h5, 4'h1, 4'hB, 16'h0360), 1'b1, 1'b1);
    check("drop_sat", 136'(drop_cnt), 136'(15));
    repeat (4) sync();
    check("drop_no_out", 136'(out_q.size()), 136'(0));
    check("drop_pend", 136'(pend), 136'(0));

    // backpressure: 16-flit packet fills source 1
    do_reset();
    tx_ready = 1'b0;
    send_pkt(1, 16, 16'h0400);
    rx_flit  = pf(1, 0, 16'h0500);
    rx_valid = 1'b1;
    rx_hdr   = 1'b1;
    rx_tail  = 1'b0;
    @(negedge clk);
    check("bp_full_ready", 136'(rx_ready), 136'(0));
    check("bp_pend", 136'(pend), 136'(4'b0010));
    sync();
    tx_ready = 1'b1;
    send_pkt(1, 2, 16'h0500);
    expect_pkt(1, 16, 16'h0400, c0, cl);
    check("bp_no_gap", 136'(cl - c0), 136'(15));
    expect_pkt(1, 2, 16'h0500, c0, cl);
    sync();
    // random ready toggling, all into source 2
    fork
      begin
        repeat (60) begin
          sync();
          tx_ready = 1'($urandom);
        end
      end
      begin
        send_pkt(2, 5, 16'h0600);
        send_pkt(2, 3, 16'h0610);
        send_pkt(2, 4, 16'h0620);
      end
    join
    sync();
    tx_ready = 1'b1;
    expect_pkt(2, 5, 16'h0600, c0, cl);
    expect_pkt(2, 3, 16'h0610, c0, cl);
    expect_pkt(2, 4, 16'h0620, c0, cl);
    sync();

    // partial packet in 0 is skipped for complete one in 1
    do_reset();
    tx_ready = 1'b0;
    send_pkt(3, 2, 16'h0700);
    send_pkt(1, 2, 16'h0710);
    send(pf(0, 0, 16'h0720), 1'b1, 1'b0);
    send(pf(0, 1, 16'h0720), 1'b0, 1'b0);
    check("part_pend", 136'(pend), 136'(4'b1010));
    tx_ready = 1'b1;
    expect_pkt(3, 2, 16'h0700, c0, cl);
    expect_pkt(1, 2, 16'h0710, c0, cl);
    repeat (3) sync();
    check("part_hold", 136'(out_q.size()), 136'(0));
    send(pf(0, 2, 16'h0720), 1'b0, 1'b1);
    expect_pkt(0, 3, 16'h0720, c0, cl);
    sync();

    // reset while a packet is being presented
    tx_ready = 1'b0;
    send_pkt(2, 3, 16'h0800);
    sync();
    check("rst_mid_valid", 136'(tx_valid), 136'(1));
    noc_rst = 1'b1;
    #1;
    check("rst_mid_tx", 136'(tx_valid), 136'(0));
    check("rst_mid_rx", 136'(rx_ready), 136'(0));
    sync();
    noc_rst = 1'b0;
    out_q.delete();
    sync();
    check("rst_post_pend", 136'(pend), 136'(0));
    check("rst_post_valid", 136'(tx_valid), 136'(0));
    tx_ready = 1'b1;
    send_pkt(2, 1, 16'h0900);
    expect_pkt(2, 1, 16'h0900, c0, cl);
    repeat (3) sync();
    check("rst_post_empty", 136'(out_q.size()), 136'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
